// File: rtl/axis_integrator.sv
// AXI-Stream saturating integrator with optional leak and output shift.
// One-deep registered output stage with full backpressure and bypass.
module axis_integrator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ACC_WIDTH        = 48,
  parameter int LEAK_SHIFT       = 16,
  parameter int OUTPUT_SHIFT     = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic                        clear,
  output logic                        overflow,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int A  = ACC_WIDTH;
  localparam int SW = ACC_WIDTH + 2;

  localparam logic signed [SW-1:0] ACC_MAX =
    {3'b000, {(A-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN =
    {3'b111, {(A-1){1'b0}}};
  localparam logic signed [A-1:0] OUT_MAX =
    {{(A-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [A-1:0] OUT_MIN =
    {{(A-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [A-1:0]  acc;
  logic signed [A-1:0]  base;
  logic signed [A-1:0]  leak;
  logic signed [A-1:0]  acc_next;
  logic signed [A-1:0]  shifted;
  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] base_ext;
  logic signed [SW-1:0] leak_ext;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         out_sat;
  logic                 acc_hi;
  logic                 acc_lo;
  logic                 out_hi;
  logic                 out_lo;
  logic                 xfer;
  logic                 ovf_next;

  assign S_AXIS_tready = ~areset & (~M_AXIS_tvalid | M_AXIS_tready);
  assign xfer          = S_AXIS_tvalid & S_AXIS_tready;

  // A clear integrates the incoming sample onto zero with no leak.
  always_comb begin
    base     = clear ? '0 : acc;
    leak     = (LEAK_SHIFT == 0 || clear) ? '0 : (acc >>> LEAK_SHIFT);
    x_ext    = {{(SW-W){S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
    base_ext = {{2{base[A-1]}}, base};
    leak_ext = {{2{leak[A-1]}}, leak};
    sum      = base_ext - leak_ext + x_ext;
    acc_hi   = sum > ACC_MAX;
    acc_lo   = sum < ACC_MIN;
    if (acc_hi)
      acc_next = {1'b0, {(A-1){1'b1}}};
    else if (acc_lo)
      acc_next = {1'b1, {(A-1){1'b0}}};
    else
      acc_next = sum[A-1:0];
    shifted = acc_next >>> OUTPUT_SHIFT;
    out_hi  = shifted > OUT_MAX;
    out_lo  = shifted < OUT_MIN;
    if (out_hi)
      out_sat = {1'b0, {(W-1){1'b1}}};
    else if (out_lo)
      out_sat = {1'b1, {(W-1){1'b0}}};
    else
      out_sat = shifted[W-1:0];
    ovf_next = clear ? 1'b0 : overflow;
    if (xfer && enable)
      ovf_next = ovf_next | acc_hi | acc_lo | out_hi | out_lo;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc           <= '0;
      overflow      <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
    end else begin
      overflow <= ovf_next;
      if (xfer) begin
        M_AXIS_tvalid <= 1'b1;
        M_AXIS_tdata  <= enable ? out_sat : S_AXIS_tdata;
        acc           <= enable ? acc_next : '0;
      end else begin
        if (M_AXIS_tready)
          M_AXIS_tvalid <= 1'b0;
        if (clear)
          acc <= '0;
      end
    end
  end

endmodule
